// File: rtl/load_store_unit.sv
// Load/store initiator: turns one execute-stage request at a time into word
// accesses on a combinational-read data memory, using read-modify-write for SB/SH.
module load_store_unit #(
  parameter int DEPTH  = 20,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_error,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t             state_reg;
  logic [2:0]         op_reg;
  logic [1:0]         addr_lo_reg;
  logic [15:0]        wdata_lo_reg;
  logic               mem_write_reg;

  logic [ADDR_W-1:0]  req_word;
  logic               req_legal;
  logic               req_misaligned;
  logic               req_oor;
  logic               req_error;
  logic [7:0]         rd_byte [4];
  logic [7:0]         lane_new [4];
  logic [3:0]         lane_hit;
  logic [31:0]        merged;
  logic [7:0]         sel_byte;
  logic [15:0]        sel_half;
  logic [31:0]        load_value;

  assign req_ready = reset && (state_reg == IDLE);
  // The write strobe must die in the very cycle reset is asserted.
  assign mem_write = mem_write_reg && reset;

  assign req_word = req_addr >> 2;

  always_comb begin
    req_legal = 1'b0;
    case (req_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: req_legal = 1'b1;
      default:                   req_legal = 1'b0;
    endcase
    req_misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_oor   = (req_word >= ADDR_W'(DEPTH));
    req_error = !req_legal || req_misaligned || req_oor;
  end

  // Big-endian lanes: byte 0 occupies the most significant bits of the word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int         HI   = 31 - 8 * gi;
      localparam logic [1:0] LANE = 2'(gi);
      assign rd_byte[gi]  = mem_rdata[HI -: 8];
      assign lane_hit[gi] = (op_reg[1:0] == 2'b00) ? (addr_lo_reg == LANE)
                                                   : (addr_lo_reg[1] == LANE[1]);
      assign lane_new[gi] = ((op_reg[1:0] == 2'b00) || LANE[0]) ? wdata_lo_reg[7:0]
                                                                : wdata_lo_reg[15:8];
      assign merged[HI -: 8] = lane_hit[gi] ? lane_new[gi] : rd_byte[gi];
    end
  endgenerate

  always_comb begin
    sel_byte = rd_byte[addr_lo_reg];
    sel_half = addr_lo_reg[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (op_reg[1:0])
      2'b00:   load_value = op_reg[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_value = op_reg[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_value = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      addr_lo_reg   <= '0;
      wdata_lo_reg  <= '0;
      mem_write_reg <= 1'b0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_error    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg       <= req_op[2:0];
            addr_lo_reg  <= req_addr[1:0];
            wdata_lo_reg <= req_wdata[15:0];
            if (req_error) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_data  <= '0;
              state_reg  <= RESP;
            end else if (req_op[3] && (req_op[1:0] == 2'b10)) begin
              mem_address   <= req_word;
              mem_wdata     <= req_wdata;
              mem_write_reg <= 1'b1;
              state_reg     <= WRITE;
            end else if (req_op[3]) begin
              mem_address <= req_word;
              state_reg   <= MERGE;
            end else begin
              mem_address <= req_word;
              state_reg   <= LOAD;
            end
          end
        end
        LOAD: begin
          resp_data   <= load_value;
          resp_error  <= 1'b0;
          resp_valid  <= 1'b1;
          mem_address <= '0;
          state_reg   <= RESP;
        end
        MERGE: begin
          mem_wdata     <= merged;
          mem_write_reg <= 1'b1;
          state_reg     <= WRITE;
        end
        WRITE: begin
          mem_write_reg <= 1'b0;
          mem_wdata     <= '0;
          mem_address   <= '0;
          resp_data     <= '0;
          resp_error    <= 1'b0;
          resp_valid    <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_data  <= '0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
